// File: rtl/bch_rx_check.sv
// Serial receive-side checker for the (64,40) systematic code: recomputes the
// 24-bit remainder bit by bit, buffers the message and reports pass/fail per frame.
module bch_rx_check #(
  parameter int N     = 64,
  parameter int K     = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     msg_data,
  output logic [23:0]      syndrome,
  output logic             crc_ok,
  output logic [CNT_W-1:0] fail_count
);

  // Feedback taps s[4], s[8], s[14], s[19]; s[23] always takes fb.
  localparam logic [23:0] TAP_MASK = 24'h084110;
  localparam int          IDX_W    = $clog2(K);
  localparam logic [6:0]  LAST_BIT = 7'(N - 1);
  localparam logic [6:0]  MSG_END  = 7'(K);

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [23:0]       s_q, s_nxt;
  logic [6:0]        bit_cnt_q, bit_cnt_nxt;
  logic [K-1:0]      msg_q;
  logic [CNT_W-1:0]  fail_q;
  logic              fb;
  logic              accept;
  logic              deliver;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    s_nxt       = s_q;
    bit_cnt_nxt = bit_cnt_q;
    accept      = 1'b0;
    deliver     = 1'b0;
    fb          = in_bit ^ s_q[0];
    case (state)
      RECV: begin
        if (abort) begin
          s_nxt       = '0;
          bit_cnt_nxt = '0;
        end else if (in_valid) begin
          accept = 1'b1;
          s_nxt  = {fb, s_q[23:1]} ^ ({24{fb}} & TAP_MASK);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = HOLD;
          end else begin
            bit_cnt_nxt = bit_cnt_q + 7'd1;
          end
        end
      end
      HOLD: begin
        // Abort outranks the output handshake: the frame is dropped uncounted.
        if (abort) begin
          s_nxt     = '0;
          state_nxt = RECV;
        end else if (out_ready) begin
          s_nxt     = '0;
          state_nxt = RECV;
          deliver   = 1'b1;
        end
      end
      default: state_nxt = RECV;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RECV;
      s_q       <= '0;
      bit_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      s_q       <= s_nxt;
      bit_cnt_q <= bit_cnt_nxt;
    end
  end

  // NOTE: the message buffer is reset on purpose so msg_data reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q <= '0;
    end else if (accept && (bit_cnt_q < MSG_END)) begin
      msg_q[bit_cnt_q[IDX_W-1:0]] <= in_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q <= '0;
    end else if (deliver && !crc_ok && (fail_q != '1)) begin
      fail_q <= fail_q + 1'b1;
    end
  end

  assign in_ready   = (state == RECV);
  assign out_valid  = (state == HOLD);
  assign msg_data   = msg_q;
  assign syndrome   = s_q;
  assign crc_ok     = (s_q == 24'h000000);
  assign fail_count = fail_q;

endmodule

// File: doc/bch_rx_check.md
Name: bch_rx_check

Overview:
- Serial receive-side checker for the (N=64, K=40) systematic code whose 24-bit parity is produced by the team's serial parity-generator register.
- Accepts a codeword one bit per handshake and recomputes the remainder with the identical 24-bit feedback register.
- Buffers the K message bits and presents message, syndrome and pass/fail flag on a valid/ready output port.
- Counts failing frames.
- Sits between the serial line deserialiser and the downstream frame consumer.

Parameters:
- N, 64, codeword length in bits.
- K, 40, message length in bits; parity width R = N-K = 24 (fixed by the polynomial; other R values are not supported).
- CNT_W, 16, width of the failed-frame counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- abort  input  1  synchronous frame abort: discard partial frame
- in_valid  input  1  serial bit offered
- in_bit  input  1  serial codeword bit
- in_ready  output  1  block accepts a bit this cycle
- out_valid  output  1  completed frame available
- out_ready  input  1  consumer accepts frame
- msg_data  output  K  received message bits; first received bit is in msg_data[0]
- syndrome  output  24  final remainder register
- crc_ok  output  1  1 when syndrome == 0
- fail_count  output  CNT_W  saturating count of frames delivered with crc_ok = 0

Behaviour:
- Bit accept: a bit is accepted when in_valid && in_ready.
- Codeword order: K message bits first, then 24 parity bits LSB-first (encoder register bit 0 first).
- Remainder register s[23:0], updated per accepted bit; fb = in_bit ^ s[0].
  - s'[23] = fb.
  - s'[i] = s[i+1] ^ fb for i in {4, 8, 14, 19}.
  - s'[i] = s[i+1] for all other i < 23.
- A valid codeword therefore leaves s = 0 after N bits.
- Bit counter: bit_cnt, 0..N-1, 7 bits wide. Accepted bits with bit_cnt < K are written to msg buffer position bit_cnt.
- FSM states:
  - RECV: in_ready = 1, out_valid = 0.
    - Each accepted bit updates s and increments bit_cnt.
    - The accept with bit_cnt == N-1 moves to HOLD and clears bit_cnt.
  - HOLD: in_ready = 0, out_valid = 1; msg_data, syndrome and crc_ok are stable.
    - On out_valid && out_ready: clear s to 0, move to RECV.
    - In the same cycle, fail_count increments if crc_ok == 0, saturating at all-ones.
- Latency: out_valid rises on the cycle after the Nth bit is accepted. A new frame's first bit can be accepted the cycle after the output handshake, so there is 1 bubble cycle.
- Output timing: msg_data and syndrome are registered outputs (not next-state values). crc_ok is combinational from the syndrome register.
- abort:
  - In RECV: clears s and bit_cnt; the bit offered that cycle is not accepted (abort overrides).
  - In HOLD: drops the frame (out_valid = 0 next cycle), clears s, returns to RECV; fail_count is not changed.
  - Abort has priority over the out_ready handshake in the same cycle.
- msg_data contents after a frame: bits keep their last values until overwritten by the next frame; msg_data is not cleared on frame boundary.
- Reset (async, any state, including mid-frame): state = RECV, s = 0, bit_cnt = 0, msg buffer = 0, fail_count = 0.
  - After reset: in_ready = 1, out_valid = 0, syndrome = 0, crc_ok = 1.
- Idle cycles: in_valid low in mid-frame leaves all state unchanged, however long the gap.

Test Plan:
- All-zero codeword, 64 bits, in_valid held high -> out_valid on cycle 65 after first accept; msg_data = 0, syndrome = 24'h000000, crc_ok = 1, fail_count = 0 after handshake.
- All-zero codeword with last bit (bit 63) = 1 -> syndrome = 24'h884110, crc_ok = 0; fail_count = 1 after handshake.
- Same with bit 62 = 1 instead -> syndrome = 24'h442088.
- Codeword generated by the team's parity generator from message 40'hA5_5A0F_F00F, parity sent LSB-first -> msg_data = 40'hA5_5A0F_F00F, crc_ok = 1.
- Backpressure and gaps:
  - Hold out_ready low for 10 cycles in HOLD -> in_ready stays 0, outputs stable, no bits lost.
  - Random in_valid gaps mid-frame -> result identical to the gap-free run.
- Abort and reset:
  - abort after 30 bits, then a clean all-zero frame -> crc_ok = 1, fail_count unchanged.
  - rst asserted mid-frame -> all outputs at reset values immediately.
  - Saturation: drive 2^CNT_W + 1 failing frames (CNT_W reduced to 2 in bench) -> fail_count sticks at 3.
